// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback controls, decode read ports and forwarding record of the RV32I writeback stage
interface wb_regfile_if;
    logic [4:0]  rd;
    logic [2:0]  load_sel;
    logic        reg_we;
    logic [1:0]  reg_sel;
    logic [31:0] res;
    logic [31:0] pc_plus_4;
    logic [31:0] mem_data;
    logic [1:0]  mem_addr_lo;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    modport master (
        output rd, load_sel, reg_we, reg_sel, res, pc_plus_4, mem_data, mem_addr_lo, rs1, rs2,
        input  rs1_data, rs2_data, wb_valid, wb_rd, wb_data
    );
    modport slave (
        input  rd, load_sel, reg_we, reg_sel, res, pc_plus_4, mem_data, mem_addr_lo, rs1, rs2,
        output rs1_data, rs2_data, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: load formatting, writeback select and 32x32 register file with write-first bypass
module wb_regfile (
    input logic          clock,
    input logic          reset,
    wb_regfile_if.slave  bus
);
    localparam logic [2:0] LOAD_B  = 3'b000;
    localparam logic [2:0] LOAD_H  = 3'b001;
    localparam logic [2:0] LOAD_BU = 3'b100;
    localparam logic [2:0] LOAD_HU = 3'b101;
    localparam logic       REG_WRITE     = 1'b1;
    localparam logic [1:0] REG_PC_PLUS_4 = 2'd1;
    localparam logic [1:0] REG_MEM       = 2'd2;

    logic [31:0] r_regs [32];
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_wdata;
    logic        w_commit;

    always_comb begin
        w_byte   = 8'(bus.mem_data >> {bus.mem_addr_lo, 3'b000});
        w_half   = bus.mem_addr_lo[1] ? bus.mem_data[31:16] : bus.mem_data[15:0];
        w_load   = (bus.load_sel == LOAD_B)  ? {{24{w_byte[7]}}, w_byte} :
                   (bus.load_sel == LOAD_BU) ? {24'd0, w_byte} :
                   (bus.load_sel == LOAD_H)  ? {{16{w_half[15]}}, w_half} :
                   (bus.load_sel == LOAD_HU) ? {16'd0, w_half} : bus.mem_data;
        w_wdata  = (bus.reg_sel == REG_PC_PLUS_4) ? bus.pc_plus_4 :
                   (bus.reg_sel == REG_MEM) ? w_load : bus.res;
        // reset suppresses the commit, which also disables the bypass
        w_commit = (bus.reg_we == REG_WRITE) && (bus.rd != 5'd0) && !reset;
        bus.rs1_data = (bus.rs1 == 5'd0) ? 32'd0 :
                       (w_commit && bus.rd == bus.rs1) ? w_wdata : r_regs[bus.rs1];
        bus.rs2_data = (bus.rs2 == 5'd0) ? 32'd0 :
                       (w_commit && bus.rd == bus.rs2) ? w_wdata : r_regs[bus.rs2];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            if (w_commit) r_regs[bus.rd] <= w_wdata;
            r_wb_valid <= w_commit;
            r_wb_rd    <= bus.rd;
            r_wb_data  <= w_wdata;
        end
    end

    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_data  = r_wb_data;
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and integer register file for the pipelined RV32I core. It consumes the writeback controls registered by the WB decoder (`rd`, `load_sel`, `reg_we`, `reg_sel`) together with the ALU result, PC+4 and the raw data-memory word. It formats load data, selects the writeback value, and commits it to a 32 x 32 register file. It also provides the two combinational read ports for decode, with same-cycle write bypass, and a registered writeback record for forwarding.

## Interface
- No parameters; XLEN fixed at 32, 32 registers.
- `clock` in 1: single core clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rd` in 5: destination register index.
- `load_sel` in 3: load format; uses the `LOAD_W/H/HU/B/BU` encodings from `codes.v`.
- `reg_we` in 1: `REG_WRITE` commits, `REG_NO_WRITE` suppresses.
- `reg_sel` in 2: writeback source; uses the `REG_RES/REG_PC_PLUS_4/REG_MEM` encodings.
- `res` in 32: ALU/execute result.
- `pc_plus_4` in 32: link value for JAL/JALR.
- `mem_data` in 32: aligned 32-bit word read from data memory.
- `mem_addr_lo` in 2: low two bits of the load's effective address.
- `rs1`, `rs2` in 5 each: read indices from decode.
- `rs1_data`, `rs2_data` out 32 each: combinational read data.
- `wb_valid` out 1: registered; a non-x0 write committed on the previous edge.
- `wb_rd` out 5: registered index of that write.
- `wb_data` out 32: registered value of that write.

## Operation
- **Load formatting** is combinational, with `a = mem_addr_lo`:
  - B: `mem_data[8a+7:8a]`, sign-extended.
  - BU: same byte, zero-extended.
  - H: `a[1] ? mem_data[31:16] : mem_data[15:0]`, sign-extended.
  - HU: same half, zero-extended.
  - W, or any undefined `load_sel`: `mem_data` unmodified. `mem_addr_lo` is ignored.
  - `a[0]` is ignored for halfwords. Misalignment is handled upstream.
- **Writeback mux**:
  - `REG_RES` selects `res`.
  - `REG_PC_PLUS_4` selects `pc_plus_4`.
  - `REG_MEM` selects the formatted load.
  - The undefined `reg_sel` code selects `res`.
- **Commit**: a commit occurs when `reg_we == REG_WRITE && rd != 0 && !reset`. The array entry `rd` takes the mux value at the edge.
- **x0**: writes to x0 are discarded. Reads of index 0 always return 0.
- **Read ports**:
  - `rsN_data` is 0 when `rsN == 0`.
  - Otherwise, if a commit is pending this cycle to `rd == rsN`, return the mux value (write-first bypass).
  - Otherwise return the array entry.
  - rs1 and rs2 bypass independently. Both may hit the same `rd`.
- **Writeback record**: each edge loads `wb_valid <= commit`, `wb_rd <= rd`, `wb_data <= mux value`. `wb_rd` and `wb_data` are "don't care" when `wb_valid` is 0, but are still loaded deterministically.
- **Reset**:
  - On an edge with `reset` high, all 31 writable registers clear to 0, and `wb_valid`, `wb_rd`, `wb_data` clear to 0.
  - Reset dominates a simultaneous commit.
  - While `reset` is high the bypass is disabled, so reads return array contents.
  - Reset asserted mid-stream discards the in-flight writeback.
- No state machine. The only state is the array and the writeback record.

## Timing
- **Write latency**: the value is visible in the array from the edge at which it commits. In the commit cycle itself it is visible through the bypass, so there is zero-cycle read-after-write for decode.
- `wb_*` outputs are valid one cycle after the commit edge.
- Read ports are purely combinational from `rs1`, `rs2`, `rd`, `reg_we`, `reg_sel`, `load_sel`, the data inputs and the array. There is no internal pipelining.
- Back-to-back commits to the same `rd` on consecutive cycles: the last one wins, and each is bypassed in its own cycle.
- Upstream holds `reg_we` at `REG_NO_WRITE` for bubbles. This block adds no stall or handshake.

## Test plan
- **Reset**: assert `reset` 2 cycles with `reg_we=REG_WRITE, rd=5, res=0xDEADBEEF`. Required: x5 reads 0 after release; `wb_valid=0`, `wb_rd=0`, `wb_data=0`.
- **Basic write and bypass**: `REG_RES`, `rd=7`, `res=0x12345678`, `rs1=7` in the same cycle. Required: `rs1_data=0x12345678` combinationally; next cycle the array reads the same; `wb_valid=1`, `wb_rd=7`.
- **x0 protection**: write `0xFFFFFFFF` to `rd=0` with `rs1=rs2=0`. Required: both reads 0; next cycle `wb_valid=0`.
- **Load formats** with `mem_data=0x80FF7F01`:
  - B with `a=0/1/2/3` gives `0x00000001 / 0x0000007F / 0xFFFFFFFF / 0xFFFFFF80`.
  - BU with `a=2` gives `0x000000FF`.
  - H with `a=2` gives `0xFFFF80FF`.
  - HU with `a=0` gives `0x00007F01`.
  - W gives `0x80FF7F01`.
- **Link and source select**: `REG_PC_PLUS_4`, `pc_plus_4=0x00000104`, `rd=1`. Required: x1 reads `0x00000104`. Undefined `reg_sel` writes `res`.
- **Reset collision and same-index reads**: commit to `rd=3` in the same edge as `reset`. Required: x3 stays 0. Separately, `rs1=rs2=rd=9` during a commit: both ports return the new value.
